// File: rtl/register_file_mp.sv
// Multi-port integer register file for the mini-rv decode stage.
// Registered read ports, one writeback port, optional write-to-read bypass.
// Storage carries no reset; after reset a sweep clears x1..x(N-1) one per cycle,
// so the array can map onto RAM.
module register_file_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int FORWARD  = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     write_en,
  input  logic [AW-1:0]            rd_addr,
  input  logic [XLEN-1:0]          rd_data,
  input  logic [NUM_READ*AW-1:0]   rs_addr,
  output logic [NUM_READ*XLEN-1:0] rs_data,
  output logic                     busy
);

  // Register count is a power of two, so the last index is all ones.
  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_IDX  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  if (NUM_REGS != 16 && NUM_REGS != 32) begin : g_bad_num_regs
    $error("register_file_mp: NUM_REGS must be 16 or 32");
  end
  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
    $error("register_file_mp: NUM_READ must be 1..4");
  end

  logic [XLEN-1:0]          mem_r [NUM_REGS];
  logic [AW-1:0]            cnt_r;
  logic                     busy_r;
  logic [NUM_READ*XLEN-1:0] rs_data_r;
  logic [NUM_READ*XLEN-1:0] rs_next_s;
  logic                     wr_fire_s;

  assign busy    = busy_r;
  assign rs_data = rs_data_r;

  // A writeback commits only when the sweep is done and the target is not x0.
  always_comb begin
    wr_fire_s = 1'b0;
    if (reset || busy_r) begin
      wr_fire_s = 1'b0;
    end else begin
      wr_fire_s = write_en && (rd_addr != ZERO_IDX);
    end
  end

  // Per-port read select: x0 is hard zero, then optional bypass, then storage.
  always_comb begin
    rs_next_s = {(NUM_READ*XLEN){1'b0}};
    for (int p = 0; p < NUM_READ; p++) begin
      if (rs_addr[p*AW +: AW] == ZERO_IDX) begin
        rs_next_s[p*XLEN +: XLEN] = {XLEN{1'b0}};
      end else if ((FORWARD != 0) && write_en && (rd_addr == rs_addr[p*AW +: AW])) begin
        rs_next_s[p*XLEN +: XLEN] = rd_data;
      end else begin
        rs_next_s[p*XLEN +: XLEN] = mem_r[rs_addr[p*AW +: AW]];
      end
    end
  end

  // Storage: clear sweep has priority over writeback; no reset on the array.
  always_ff @(posedge clk) begin
    if (!reset && busy_r) begin
      mem_r[cnt_r] <= {XLEN{1'b0}};
    end else if (wr_fire_s) begin
      mem_r[rd_addr] <= rd_data;
    end
  end

  // Sweep control: reset (re)starts at x1, busy drops on the edge that clears the last reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b1;
      cnt_r  <= ONE_IDX;
    end else if (busy_r) begin
      cnt_r <= cnt_r + ONE_IDX;
      if (cnt_r == LAST_IDX) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Read-data registers: zero during reset and sweep, hold under stall.
  always_ff @(posedge clk) begin
    if (reset || busy_r) begin
      rs_data_r <= {(NUM_READ*XLEN){1'b0}};
    end else if (!stall) begin
      rs_data_r <= rs_next_s;
    end
  end

endmodule
